// File: rtl/shared_resource_arbiter_if.sv
// shared_resource_arbiter_if: request/grant, resource and response signals between requesters and the arbiter.
// Signals:
//    req             - per-requester level request
//    req_data        - requester i owns bits [i*DATA_W +: DATA_W]
//    grant           - registered one-hot (or zero) grant
//    resource_input  - granted requester's data, zero when no transfer
//    resource_valid  - a transfer happens this cycle
//    resource_output - result from the shared resource, RES_LAT cycles after its transfer
//    rsp_data        - resource_output passed through while a response is valid, else zero
//    rsp_valid       - one-hot owner of rsp_data
//    busy            - grant active or any operation in flight
// Modports: master = requester/resource side, slave = arbiter.
interface shared_resource_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        grant;
   logic [DATA_W-1:0]         resource_input;
   logic                      resource_valid;
   logic [DATA_W-1:0]         resource_output;
   logic [DATA_W-1:0]         rsp_data;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic                      busy;
   modport master (
      output req, req_data, resource_output,
      input  grant, resource_input, resource_valid, rsp_data, rsp_valid, busy
   );
   modport slave (
      input  req, req_data, resource_output,
      output grant, resource_input, resource_valid, rsp_data, rsp_valid, busy
   );
endinterface

// File: rtl/shared_resource_arbiter.sv
// shared_resource_arbiter: round-robin arbiter sharing one fixed-latency resource between NUM_REQ requesters.
// Ports:
//    clk   - clock, rising edge
//    reset - asynchronous active-low reset
//    bus   - shared_resource_arbiter_if.slave: req/req_data/resource_output in;
//            grant/resource_input/resource_valid/rsp_data/rsp_valid/busy out
// Macro ARB_BURST_LIMIT_EN: when defined, a grant is released after MAX_BURST consecutive transfers
// if another requester is waiting; when undefined a grant is held until its req drops.
module shared_resource_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 32,
   parameter int RES_LAT   = 2,
   parameter int MAX_BURST = 4
) (
   input logic                      clk,
   input logic                      reset,
   shared_resource_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   if (NUM_REQ < 2 || NUM_REQ > 8 || RES_LAT < 1 || MAX_BURST < 1) begin : g_param_check
      $error("shared_resource_arbiter: parameter out of range");
   end
   typedef enum logic {IDLE, OWNED} state_t;
   state_t             r_state, w_state_nxt;
   logic [IW-1:0]      r_owner, w_owner_nxt, r_last, w_last_nxt, w_start, w_pick;
   logic [NUM_REQ-1:0] w_grant, w_mask;
   logic [DATA_W-1:0]  w_din;
   logic               w_found, w_xfer, w_rel_b;
   logic [RES_LAT-1:0] r_pipe_v;
   logic [IW-1:0]      r_pipe_o [RES_LAT];

   assign w_grant = (r_state == OWNED) ? NUM_REQ'(1) << r_owner : '0;
   assign w_xfer  = |(w_grant & bus.req);

   always_comb begin
      w_din = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (w_grant[i] && bus.req[i]) w_din = bus.req_data[i*DATA_W +: DATA_W];
   end

   // Rotating search starting after the owner (after last when idle). The owner is masked out,
   // so a release hands off to the next waiting requester in the same cycle.
   always_comb begin
      w_start = (r_state == OWNED) ? r_owner : r_last;
      w_mask  = bus.req & ~w_grant;
      w_pick  = '0;
      w_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++)
         if (!w_found && w_mask[IW'((int'(w_start) + k) % NUM_REQ)]) begin
            w_pick  = IW'((int'(w_start) + k) % NUM_REQ);
            w_found = 1'b1;
         end
   end

`ifdef ARB_BURST_LIMIT_EN
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   logic [BW-1:0] r_burst_cnt;
   logic          w_at_limit;
   // At the limit with nobody waiting the grant is kept and the count simply restarts.
   assign w_at_limit = w_xfer && (r_burst_cnt == BW'(MAX_BURST - 1));
   assign w_rel_b    = w_at_limit && w_found;
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_burst_cnt <= '0;
      else r_burst_cnt <= (w_at_limit || w_state_nxt != r_state || w_owner_nxt != r_owner) ?
                          '0 : r_burst_cnt + BW'(w_xfer);
`else
   assign w_rel_b = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      if (r_state == IDLE) begin
         w_state_nxt = w_found ? OWNED : IDLE;
         w_owner_nxt = w_found ? w_pick : r_owner;
      end else if (!bus.req[r_owner] || w_rel_b) begin
         w_last_nxt  = r_owner;
         w_state_nxt = w_found ? OWNED : IDLE;
         w_owner_nxt = w_found ? w_pick : r_owner;
      end
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_last  <= IW'(NUM_REQ - 1);
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_last  <= w_last_nxt;
      end

   // Each transfer carries its owner down the pipe so the result returns to whoever issued it.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_pipe_v <= '0;
         for (int k = 0; k < RES_LAT; k++) r_pipe_o[k] <= '0;
      end else begin
         r_pipe_v[0] <= w_xfer;
         r_pipe_o[0] <= r_owner;
         for (int k = 1; k < RES_LAT; k++) begin
            r_pipe_v[k] <= r_pipe_v[k-1];
            r_pipe_o[k] <= r_pipe_o[k-1];
         end
      end

   assign bus.grant          = w_grant;
   assign bus.resource_valid = w_xfer;
   assign bus.resource_input = w_din;
   assign bus.rsp_valid      = r_pipe_v[RES_LAT-1] ? NUM_REQ'(1) << r_pipe_o[RES_LAT-1] : '0;
   assign bus.rsp_data       = r_pipe_v[RES_LAT-1] ? bus.resource_output : '0;
   assign bus.busy           = (|w_grant) || (|r_pipe_v);
endmodule
